// File: rtl/eeg_aram_rd_agen.sv
// ARAM read address generator with a credit-limited return-data FIFO.
// Optional stall counter is compiled in when AGEN_PERF_EN is defined.
module eeg_aram_rd_agen #(
  parameter int ADD_AW     = 12,
  parameter int DAT_DW     = 8,
  parameter int LEN_DW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              IS_IDLE,
  input  logic              CFG_INFO_VLD,
  output logic              CFG_INFO_RDY,
  input  logic [ADD_AW-1:0] CFG_BASE_ADD,
  input  logic [LEN_DW-1:0] CFG_COL_NUM,
  input  logic [LEN_DW-1:0] CFG_ROW_NUM,
  input  logic [ADD_AW-1:0] CFG_ROW_STRIDE,
  output logic              ETOA_ADD_VLD,
  output logic              ETOA_ADD_LST,
  output logic              ETOA_ADD_END,
  input  logic              ETOA_ADD_RDY,
  output logic [ADD_AW-1:0] ETOA_ADD_ADD,
  input  logic              ATOE_DAT_VLD,
  input  logic              ATOE_DAT_LST,
  output logic              ATOE_DAT_RDY,
  input  logic [DAT_DW-1:0] ATOE_DAT_DAT,
`ifdef AGEN_PERF_EN
  output logic [15:0]       PERF_STALL_CNT,
`endif
  output logic              DOUT_VLD,
  output logic              DOUT_LST,
  output logic              DOUT_END,
  input  logic              DOUT_RDY,
  output logic [DAT_DW-1:0] DOUT_DAT
);

  // state   | meaning
  // S_IDLE  | waiting for a window configuration
  // S_ISSUE | issuing read addresses, credit permitting
  // S_DRAIN | all addresses issued, waiting for the window-last beat to leave
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_t            state;
  logic [LEN_DW-1:0] cfg_col;
  logic [ADD_AW-1:0] cfg_stride;
  logic [ADD_AW-1:0] row_base;
  logic [ADD_AW-1:0] cur_add;
  logic [LEN_DW-1:0] col_rem;
  logic [LEN_DW-1:0] row_rem;
  logic [LEN_DW-1:0] ret_col;
  logic [LEN_DW-1:0] ret_row;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DAT_DW-1:0] mem_dat [FIFO_DEPTH];
  logic              mem_lst [FIFO_DEPTH];
  logic              mem_end [FIFO_DEPTH];

  logic [CW:0]       credit_used;
  logic              credit_ok;
  logic              in_issue;
  logic              cfg_hs;
  logic              addr_hs;
  logic              add_lst;
  logic              add_end;
  logic              push;
  logic              pop;
  logic              ret_end;
  logic [ADD_AW-1:0] next_row_base;

  assign IS_IDLE       = (state == S_IDLE);
  assign CFG_INFO_RDY  = IS_IDLE;
  assign cfg_hs        = CFG_INFO_VLD & IS_IDLE;
  assign in_issue      = (state == S_ISSUE);

  // Every issued address owns a FIFO slot until its beat leaves on DOUT.
  assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign credit_ok     = credit_used < (CW+1)'(FIFO_DEPTH);

  assign add_lst       = (col_rem == '0);
  assign add_end       = add_lst & (row_rem == '0);
  assign ETOA_ADD_VLD  = in_issue & credit_ok;
  assign ETOA_ADD_LST  = in_issue & add_lst;
  assign ETOA_ADD_END  = in_issue & add_end;
  assign ETOA_ADD_ADD  = cur_add;
  assign addr_hs       = ETOA_ADD_VLD & ETOA_ADD_RDY;
  assign next_row_base = row_base + cfg_stride;

  assign ATOE_DAT_RDY  = ~IS_IDLE & (fifo_cnt != CW'(FIFO_DEPTH));
  assign push          = ATOE_DAT_VLD & ATOE_DAT_RDY;
  assign ret_end       = (ret_col == '0) & (ret_row == '0);

  assign DOUT_VLD      = (fifo_cnt != '0);
  assign DOUT_DAT      = DOUT_VLD ? mem_dat[rd_ptr] : '0;
  assign DOUT_LST      = DOUT_VLD & mem_lst[rd_ptr];
  assign DOUT_END      = DOUT_VLD & mem_end[rd_ptr];
  assign pop           = DOUT_VLD & DOUT_RDY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_col    <= '0;
      cfg_stride <= '0;
      row_base   <= '0;
      cur_add    <= '0;
      col_rem    <= '0;
      row_rem    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CFG_INFO_VLD) begin
            cfg_col    <= CFG_COL_NUM;
            cfg_stride <= CFG_ROW_STRIDE;
            row_base   <= CFG_BASE_ADD;
            cur_add    <= CFG_BASE_ADD;
            col_rem    <= CFG_COL_NUM;
            row_rem    <= CFG_ROW_NUM;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (addr_hs) begin
            if (add_lst) begin
              row_base <= next_row_base;
              cur_add  <= next_row_base;
              col_rem  <= cfg_col;
              row_rem  <= row_rem - LEN_DW'(1);
            end else begin
              cur_add  <= cur_add + ADD_AW'(1);
              col_rem  <= col_rem - LEN_DW'(1);
            end
            if (add_end) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && DOUT_END) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return-side beat counter marks the window-last beat independently of the address side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_col     <= '0;
      ret_row     <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (cfg_hs) begin
        ret_col <= CFG_COL_NUM;
        ret_row <= CFG_ROW_NUM;
      end else if (push) begin
        if (ret_col == '0) begin
          ret_col <= cfg_col;
          ret_row <= ret_row - LEN_DW'(1);
        end else begin
          ret_col <= ret_col - LEN_DW'(1);
        end
      end
      case ({addr_hs, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= ATOE_DAT_DAT;
      mem_lst[wr_ptr] <= ATOE_DAT_LST;
      mem_end[wr_ptr] <= ret_end;
    end
  end

`ifdef AGEN_PERF_EN
  logic stall;
  assign stall = in_issue & ~(credit_ok & ETOA_ADD_RDY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   PERF_STALL_CNT <= '0;
    else if (cfg_hs)                           PERF_STALL_CNT <= '0;
    else if (stall && PERF_STALL_CNT != 16'hFFFF) PERF_STALL_CNT <= PERF_STALL_CNT + 16'd1;
  end
`endif

endmodule
